// File: rtl/vga_pkg.sv
// Shared types and defaults for the VGA SRAM scheduler: FSM state encoding,
// SRAM geometry and the default write-window limit.
package vga_pkg;

  localparam int VGA_ADDR_W      = 18;
  localparam int VGA_DATA_W      = 16;
  localparam int VGA_COLS        = 640;
  localparam int VGA_WIN_TIMEOUT = 20000;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARM   = 2'd1,
    S_WRITE = 2'd2,
    S_HOLD  = 2'd3
  } sched_state_e;

endpackage

// File: rtl/vga_sram_port.sv
// SRAM pin registers and read-data capture pipeline. Takes a one-hot
// {wr, rd} command each cycle and presents registered strobes/address/data.
module vga_sram_port
  import vga_pkg::*;
#(
  parameter int ADDR_W = VGA_ADDR_W,
  parameter int DATA_W = VGA_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_wr,
  input  logic              cmd_rd,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] sram_dq_i,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_dq_o,
  output logic              sram_dq_oe,
  output logic              sram_ce_n,
  output logic              sram_oe_n,
  output logic              sram_we_n,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid
);

  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] dq_o_q, dq_o_d;
  logic              dq_oe_q, dq_oe_d;
  logic              ce_n_q, ce_n_d;
  logic              oe_n_q, oe_n_d;
  logic              we_n_q, we_n_d;
  logic              rd_pend_q, rd_pend_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              rd_valid_q, rd_valid_d;

  // NOTE: every signal gets a default before the if/else so no path leaves
  // it unassigned; otherwise synthesis infers a latch.
  always_comb begin
    addr_d     = addr_q;
    dq_o_d     = dq_o_q;
    dq_oe_d    = 1'b0;
    ce_n_d     = 1'b1;
    oe_n_d     = 1'b1;
    we_n_d     = 1'b1;
    rd_pend_d  = cmd_rd && !cmd_wr;
    rd_valid_d = rd_pend_q;
    rd_data_d  = rd_pend_q ? sram_dq_i : rd_data_q;
    if (cmd_wr) begin
      addr_d  = wr_addr;
      dq_o_d  = wr_data;
      dq_oe_d = 1'b1;
      ce_n_d  = 1'b0;
      we_n_d  = 1'b0;
    end else if (cmd_rd) begin
      // DQ_OE drops in the same update that opens OE_N: no drive/receive overlap.
      addr_d = rd_addr;
      ce_n_d = 1'b0;
      oe_n_d = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q     <= '0;
      dq_o_q     <= '0;
      dq_oe_q    <= 1'b0;
      ce_n_q     <= 1'b1;
      oe_n_q     <= 1'b1;
      we_n_q     <= 1'b1;
      rd_pend_q  <= 1'b0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      addr_q     <= addr_d;
      dq_o_q     <= dq_o_d;
      dq_oe_q    <= dq_oe_d;
      ce_n_q     <= ce_n_d;
      oe_n_q     <= oe_n_d;
      we_n_q     <= we_n_d;
      rd_pend_q  <= rd_pend_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  assign sram_addr  = addr_q;
  assign sram_dq_o  = dq_o_q;
  assign sram_dq_oe = dq_oe_q;
  assign sram_ce_n  = ce_n_q;
  assign sram_oe_n  = oe_n_q;
  assign sram_we_n  = we_n_q;
  assign rd_data    = rd_data_q;
  assign rd_valid   = rd_valid_q;

endmodule

// File: rtl/vga_ram_sched.sv
// VGA SRAM scheduler: grants one write window per captured trigger during
// vertical blank and serves display reads with fixed 2-cycle latency otherwise.
module vga_ram_sched
  import vga_pkg::*;
#(
  parameter int ADDR_W      = VGA_ADDR_W,
  parameter int DATA_W      = VGA_DATA_W,
  parameter int WIN_TIMEOUT = VGA_WIN_TIMEOUT
) (
  input  logic              CLK_50MHZ,
  input  logic              MASTER_RST_N,
  input  logic              CAPTURE_READY,
  output logic              CAPTURE_ACK,
  input  logic              VBLANK,
  output logic              ACCESS_OK,
  input  logic [ADDR_W-1:0] WR_ADDR,
  input  logic [DATA_W-1:0] WR_DATA,
  input  logic              WRITE_DONE,
  input  logic              RD_REQ,
  input  logic [ADDR_W-1:0] RD_ADDR,
  output logic [DATA_W-1:0] RD_DATA,
  output logic              RD_VALID,
  output logic              WRITE_ABORT,
  output logic              RD_DROP,
  output logic [ADDR_W-1:0] SRAM_ADDR,
  output logic [DATA_W-1:0] SRAM_DQ_O,
  output logic              SRAM_DQ_OE,
  input  logic [DATA_W-1:0] SRAM_DQ_I,
  output logic              SRAM_CE_N,
  output logic              SRAM_OE_N,
  output logic              SRAM_WE_N
);

  localparam int              CNT_W    = $clog2(WIN_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIN_TIMEOUT - 1);

  logic [1:0]       rst_sync_q, rst_sync_d;
  logic             rst_n;
  sched_state_e     state_q, state_d;
  logic             vblank_prev_q, vblank_prev_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             access_ok_q, access_ok_d;
  logic             capture_ack_q, capture_ack_d;
  logic             write_abort_q, write_abort_d;
  logic             rd_drop_q, rd_drop_d;
  logic             win_done, win_abort, in_write, cmd_wr, cmd_rd;

  // Assertion is asynchronous; release is held off for two clock edges.
  assign rst_sync_d = {rst_sync_q[0], 1'b1};
  always_ff @(posedge CLK_50MHZ or negedge MASTER_RST_N) begin
    if (!MASTER_RST_N) rst_sync_q <= 2'b00;
    else               rst_sync_q <= rst_sync_d;
  end
  assign rst_n = rst_sync_q[1];

  always_ff @(posedge CLK_50MHZ or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    win_done  = 1'b0;
    win_abort = 1'b0;
    case (state_q)
      S_IDLE:  if (CAPTURE_READY) state_d = S_ARM;
      S_ARM: begin
        // Only a fresh rising edge opens a window, never a blank already underway.
        if (!CAPTURE_READY)                state_d = S_IDLE;
        else if (VBLANK && !vblank_prev_q) state_d = S_WRITE;
      end
      S_WRITE: begin
        if (WRITE_DONE) begin
          state_d  = S_HOLD;
          win_done = 1'b1;
        end else if (!VBLANK || cnt_q == CNT_LAST) begin
          state_d   = S_HOLD;
          win_abort = 1'b1;
        end
      end
      S_HOLD:  if (!VBLANK) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    in_write      = (state_q == S_WRITE);
    access_ok_d   = (state_d == S_WRITE);
    capture_ack_d = win_done || win_abort;
    write_abort_d = win_abort;
    rd_drop_d     = rd_drop_q || (RD_REQ && in_write);
    cnt_d         = in_write ? cnt_q + CNT_W'(1) : '0;
    vblank_prev_d = VBLANK;
    cmd_wr        = in_write;
    cmd_rd        = RD_REQ && !in_write;
  end

  always_ff @(posedge CLK_50MHZ or negedge rst_n) begin
    if (!rst_n) begin
      vblank_prev_q <= 1'b0;
      cnt_q         <= '0;
      access_ok_q   <= 1'b0;
      capture_ack_q <= 1'b0;
      write_abort_q <= 1'b0;
      rd_drop_q     <= 1'b0;
    end else begin
      vblank_prev_q <= vblank_prev_d;
      cnt_q         <= cnt_d;
      access_ok_q   <= access_ok_d;
      capture_ack_q <= capture_ack_d;
      write_abort_q <= write_abort_d;
      rd_drop_q     <= rd_drop_d;
    end
  end

  assign ACCESS_OK   = access_ok_q;
  assign CAPTURE_ACK = capture_ack_q;
  assign WRITE_ABORT = write_abort_q;
  assign RD_DROP     = rd_drop_q;

  vga_sram_port #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_port (
    .clk        (CLK_50MHZ),
    .rst_n      (rst_n),
    .cmd_wr     (cmd_wr),
    .cmd_rd     (cmd_rd),
    .wr_addr    (WR_ADDR),
    .wr_data    (WR_DATA),
    .rd_addr    (RD_ADDR),
    .sram_dq_i  (SRAM_DQ_I),
    .sram_addr  (SRAM_ADDR),
    .sram_dq_o  (SRAM_DQ_O),
    .sram_dq_oe (SRAM_DQ_OE),
    .sram_ce_n  (SRAM_CE_N),
    .sram_oe_n  (SRAM_OE_N),
    .sram_we_n  (SRAM_WE_N),
    .rd_data    (RD_DATA),
    .rd_valid   (RD_VALID)
  );

endmodule

// File: tb/tb_vga_ram_sched.sv
// Scoreboard bench for vga_ram_sched: stimulus queues expected writes, reads
// and ACK/ABORT events; one monitor process pops and compares on DUT outputs.
module tb_vga_ram_sched;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Main instance (default window limit)
  logic        rst_n = 1'b1, cap_ready = 1'b0, vblank = 1'b0, write_done = 1'b0;
  logic        rd_req = 1'b0;
  logic [17:0] wr_addr = '0, rd_addr = '0;
  logic [15:0] wr_data = '0;
  logic        capture_ack, access_ok, rd_valid, write_abort, rd_drop;
  logic [15:0] rd_data, sram_dq_o, sram_dq_i;
  logic [17:0] sram_addr;
  logic        sram_dq_oe, sram_ce_n, sram_oe_n, sram_we_n;

  // Second instance with a short window limit
  logic        rst2_n = 1'b1, cap2 = 1'b0, vb2 = 1'b0;
  logic        capture_ack2, access_ok2, rd_valid2, write_abort2, rd_drop2;
  logic [15:0] rd_data2, sram_dq_o2;
  logic [17:0] sram_addr2;
  logic        sram_dq_oe2, sram_ce_n2, sram_oe_n2, sram_we_n2;

  // SRAM read model: data = addr ^ A5A5 while selected and output-enabled
  assign sram_dq_i = (!sram_ce_n && !sram_oe_n) ? (sram_addr[15:0] ^ 16'hA5A5) : 16'h0000;

  vga_ram_sched dut (
    .CLK_50MHZ(clk), .MASTER_RST_N(rst_n), .CAPTURE_READY(cap_ready),
    .CAPTURE_ACK(capture_ack), .VBLANK(vblank), .ACCESS_OK(access_ok),
    .WR_ADDR(wr_addr), .WR_DATA(wr_data), .WRITE_DONE(write_done),
    .RD_REQ(rd_req), .RD_ADDR(rd_addr), .RD_DATA(rd_data), .RD_VALID(rd_valid),
    .WRITE_ABORT(write_abort), .RD_DROP(rd_drop), .SRAM_ADDR(sram_addr),
    .SRAM_DQ_O(sram_dq_o), .SRAM_DQ_OE(sram_dq_oe), .SRAM_DQ_I(sram_dq_i),
    .SRAM_CE_N(sram_ce_n), .SRAM_OE_N(sram_oe_n), .SRAM_WE_N(sram_we_n)
  );

  vga_ram_sched #(.WIN_TIMEOUT(100)) dut_to (
    .CLK_50MHZ(clk), .MASTER_RST_N(rst2_n), .CAPTURE_READY(cap2),
    .CAPTURE_ACK(capture_ack2), .VBLANK(vb2), .ACCESS_OK(access_ok2),
    .WR_ADDR(wr_addr), .WR_DATA(wr_data), .WRITE_DONE(1'b0),
    .RD_REQ(1'b0), .RD_ADDR(18'h0), .RD_DATA(rd_data2), .RD_VALID(rd_valid2),
    .WRITE_ABORT(write_abort2), .RD_DROP(rd_drop2), .SRAM_ADDR(sram_addr2),
    .SRAM_DQ_O(sram_dq_o2), .SRAM_DQ_OE(sram_dq_oe2), .SRAM_DQ_I(16'h0000),
    .SRAM_CE_N(sram_ce_n2), .SRAM_OE_N(sram_oe_n2), .SRAM_WE_N(sram_we_n2)
  );

  typedef struct {
    int          cyc;
    logic [15:0] data;
  } rd_exp_t;

  logic [33:0] wr_q[$];   // {addr, data}
  rd_exp_t     rd_q[$];
  logic [1:0]  ev_q[$];   // {ack, abort}
  logic [1:0]  ev2_q[$];

  int total = 0, bad = 0;
  int cyc = 0, acc_cnt = 0, acc2_cnt = 0, ce_low_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: samples on the falling edge, pops expectations as outputs appear
  always @(negedge clk) begin
    if (access_ok)   acc_cnt++;
    if (access_ok2)  acc2_cnt++;
    if (!sram_ce_n)  ce_low_cnt++;
    if (!sram_we_n) begin
      if (wr_q.size() == 0) check("wr_unexpected", 64'(sram_we_n), 64'd1);
      else begin
        logic [33:0] w;
        w = wr_q.pop_front();
        check("wr_beat", {sram_addr, sram_dq_o, sram_dq_oe, sram_oe_n, sram_ce_n},
              {w, 1'b1, 1'b1, 1'b0});
      end
    end
    if (!sram_oe_n) check("turnaround", {sram_dq_oe, sram_we_n}, 2'b01);
    if (rd_valid) begin
      if (rd_q.size() == 0) check("rd_unexpected", 64'(rd_valid), 64'd0);
      else begin
        rd_exp_t r;
        r = rd_q.pop_front();
        check("rd_data", rd_data, r.data);
        check("rd_latency", cyc, r.cyc);
      end
    end
    if (capture_ack || write_abort) begin
      if (ev_q.size() == 0) check("ev_unexpected", {capture_ack, write_abort}, 2'b00);
      else check("ack_abort", {capture_ack, write_abort}, ev_q.pop_front());
    end
    if (capture_ack2 || write_abort2) begin
      if (ev2_q.size() == 0) check("ev2_unexpected", {capture_ack2, write_abort2}, 2'b00);
      else check("ack_abort2", {capture_ack2, write_abort2}, ev2_q.pop_front());
    end
  end

  localparam logic [15:0] RD_EXP[4] = '{16'hA5AF, 16'hA5AE, 16'hA5A9, 16'hA5A8};

  initial begin
    int acc0, ce0;
    #1 rst_n = 1'b0; rst2_n = 1'b0;
    tick(); tick();
    check("rst_flags", {access_ok, capture_ack, write_abort, rd_drop, rd_valid,
                        sram_ce_n, sram_oe_n, sram_we_n, sram_dq_oe}, 9'b00000_1110);
    check("rst_buses", {sram_addr, sram_dq_o, rd_data}, 50'h0);
    rst_n = 1'b1; rst2_n = 1'b1;
    repeat (5) tick();

    // Three frames with no capture pending
    acc0 = acc_cnt; ce0 = ce_low_cnt;
    repeat (3) begin
      vblank = 1'b1; repeat (30) tick();
      vblank = 1'b0; repeat (30) tick();
    end
    check("idle_no_window", acc_cnt - acc0, 0);
    check("idle_ce_high", ce_low_cnt - ce0, 0);

    // Full 16000-word window closed by WRITE_DONE
    cap_ready = 1'b1; repeat (5) tick();
    for (int k = 0; k < 16000; k++) wr_q.push_back({18'(k), 16'(k) ^ 16'h3C3C});
    ev_q.push_back(2'b10);
    acc0 = acc_cnt;
    check("win_not_before_rise", access_ok, 1'b0);
    vblank = 1'b1;
    tick();
    for (int k = 0; k < 16000; k++) begin
      if (k == 0) check("win_opens_next", access_ok, 1'b1);
      wr_addr = 18'(k); wr_data = 16'(k) ^ 16'h3C3C;
      write_done = (k == 15999);
      tick();
    end
    write_done = 1'b0;
    check("win_closed", access_ok, 1'b0);
    check("win_len_16000", acc_cnt - acc0, 16000);
    repeat (5) tick();
    cap_ready = 1'b0; vblank = 1'b0; repeat (10) tick();

    // Capture arrives mid-blank: must wait for the next rising edge
    vblank = 1'b1; repeat (10) tick();
    cap_ready = 1'b1; acc0 = acc_cnt; repeat (50) tick();
    check("midblank_no_window", acc_cnt - acc0, 0);
    vblank = 1'b0; repeat (5) tick();
    for (int k = 0; k < 8; k++) wr_q.push_back({18'(100 + k), 16'(100 + k) ^ 16'h3C3C});
    ev_q.push_back(2'b10);
    vblank = 1'b1;
    tick();
    for (int k = 0; k < 8; k++) begin
      wr_addr = 18'(100 + k); wr_data = 16'(100 + k) ^ 16'h3C3C;
      write_done = (k == 7);
      tick();
    end
    write_done = 1'b0;
    check("nextblank_len_8", acc_cnt - acc0, 8);
    cap_ready = 1'b0; vblank = 1'b0; repeat (5) tick();

    // CAPTURE_READY withdrawn while armed
    cap_ready = 1'b1; repeat (3) tick();
    cap_ready = 1'b0; repeat (3) tick();
    acc0 = acc_cnt;
    vblank = 1'b1; repeat (20) tick();
    check("arm_drop_no_window", acc_cnt - acc0, 0);
    vblank = 1'b0; repeat (5) tick();

    // Blank ends early: abort, dropped read inside window, read right after
    check("rd_drop_clear", rd_drop, 1'b0);
    cap_ready = 1'b1; repeat (3) tick();
    for (int k = 0; k <= 5000; k++) wr_q.push_back({18'(2000 + k), 16'(k) ^ 16'h5A5A});
    ev_q.push_back(2'b11);
    acc0 = acc_cnt;
    vblank = 1'b1;
    tick();
    for (int k = 0; k <= 5000; k++) begin
      wr_addr = 18'(2000 + k); wr_data = 16'(k) ^ 16'h5A5A;
      rd_req = (k == 10); rd_addr = 18'd5;
      if (k == 5000) vblank = 1'b0;
      tick();
    end
    check("abort_access_low", access_ok, 1'b0);
    rd_req = 1'b1; rd_addr = 18'd20;
    rd_q.push_back('{cyc: cyc + 2, data: 16'hA5B1});
    tick();
    rd_req = 1'b0;
    check("turnaround_pins", {sram_oe_n, sram_dq_oe, sram_ce_n, sram_we_n}, 4'b0001);
    check("abort_len", acc_cnt - acc0, 5001);
    check("rd_drop_set", rd_drop, 1'b1);
    cap_ready = 1'b0; repeat (10) tick();

    // Back-to-back display reads, addresses 10..13
    for (int i = 0; i < 4; i++) begin
      rd_req = 1'b1; rd_addr = 18'(10 + i);
      rd_q.push_back('{cyc: cyc + 2, data: RD_EXP[i]});
      tick();
    end
    rd_req = 1'b0; repeat (5) tick();
    check("rd_drop_sticky", rd_drop, 1'b1);

    // Timeout instance: VBLANK held high, exactly 100 window cycles, one per blank
    cap2 = 1'b1; repeat (3) tick();
    ev2_q.push_back(2'b11);
    acc0 = acc2_cnt;
    vb2 = 1'b1; repeat (250) tick();
    check("timeout_len_100", acc2_cnt - acc0, 100);
    vb2 = 1'b0; repeat (5) tick();
    vb2 = 1'b1; repeat (20) tick();
    check("rewindow_open", {access_ok2, sram_we_n2}, 2'b10);
    #2 rst2_n = 1'b0;
    #1 check("async_rst_mid_window", {access_ok2, sram_we_n2, capture_ack2}, 3'b010);
    tick();
    rst2_n = 1'b1; cap2 = 1'b0; vb2 = 1'b0; repeat (5) tick();

    check("wr_q_drained", wr_q.size(), 0);
    check("rd_q_drained", rd_q.size(), 0);
    check("ev_q_drained", ev_q.size(), 0);
    check("ev2_q_drained", ev2_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
